servant_wb_arbiter: RTL and testbench

//  - Two-master, one-slave Wishbone arbiter; lets a second master share the servant SRAM port with the SERV CPU.
//  - M0 = CPU memory bus (ibus/dbus already muxed); M1 = program-loader/debug master.
//  - Placed between those masters and the servant RAM, inside the wb_clk domain behind the Gowin rPLL.
//  - Round-robin between requesters; bus held for the full cycle; optional hung-access timeout.

---
 rtl/servant_wb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_servant_wb_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/servant_wb_arbiter.sv
// servant_wb_arbiter: two-master / one-slave Wishbone arbiter for the servant SRAM.
// M0 = CPU memory bus, M1 = loader/debug master. Round-robin on ties, and the
// owner keeps the bus until it drops cyc. A grant is always followed by at least
// one idle cycle.
// Optional hung-access timeout is enabled with macro SERVANT_WB_ARB_TIMEOUT_EN.
module servant_wb_arbiter #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic [AW-1:0] i_m0_adr,
    input  logic [31:0]   i_m0_dat,
    input  logic [3:0]    i_m0_sel,
    input  logic          i_m0_we,
    input  logic          i_m0_cyc,
    output logic [31:0]   o_m0_rdt,
    output logic          o_m0_ack,
    output logic          o_m0_err,
    input  logic [AW-1:0] i_m1_adr,
    input  logic [31:0]   i_m1_dat,
    input  logic [3:0]    i_m1_sel,
    input  logic          i_m1_we,
    input  logic          i_m1_cyc,
    output logic [31:0]   o_m1_rdt,
    output logic          o_m1_ack,
    output logic          o_m1_err,
    output logic [AW-1:0] o_s_adr,
    output logic [31:0]   o_s_dat,
    output logic [3:0]    o_s_sel,
    output logic          o_s_we,
    output logic          o_s_cyc,
    input  logic [31:0]   i_s_rdt,
    input  logic          i_s_ack,
    output logic [1:0]    o_grant,
    output logic          o_tmo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_owner, last_owner_nxt;  // 0 = M0, 1 = M1; reset to M1 so M0 wins the first tie
    logic   tmo_hit;                     // owner is terminated this cycle

`ifdef SERVANT_WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt;
    logic          tmo_q;
    logic          own_cyc;

    assign own_cyc = (state == OWN0) ? i_m0_cyc : (state == OWN1) ? i_m1_cyc : 1'b0;
    // A same-cycle ack always beats the timeout, so the access completes normally.
    assign tmo_hit = own_cyc && !i_s_ack && (cnt == CW'(TIMEOUT - 1));
    assign o_tmo   = tmo_q;

    // Stall counter: zero while idle (so each grant starts at 0), restarts on every ack.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cnt   <= '0;
            tmo_q <= 1'b0;
        end else begin
            if (state == IDLE || i_s_ack || state_nxt == IDLE)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (tmo_hit)
                tmo_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign o_tmo   = 1'b0;
`endif

    // Registered ownership state and round-robin history.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // Arbitration and release: grants only from IDLE, owner leaves on cyc drop or timeout.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc)
                    state_nxt = last_owner ? OWN0 : OWN1;
                else if (i_m0_cyc)
                    state_nxt = OWN0;
                else if (i_m1_cyc)
                    state_nxt = OWN1;
            end
            OWN0: begin
                if (!i_m0_cyc || tmo_hit) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = 1'b0;
                end
            end
            OWN1: begin
                if (!i_m1_cyc || tmo_hit) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus mux driven from the registered state; the non-owner sees all zeros.
    always_comb begin
        o_s_adr  = '0;
        o_s_dat  = '0;
        o_s_sel  = '0;
        o_s_we   = 1'b0;
        o_s_cyc  = 1'b0;
        o_m0_rdt = '0;
        o_m0_ack = 1'b0;
        o_m0_err = 1'b0;
        o_m1_rdt = '0;
        o_m1_ack = 1'b0;
        o_m1_err = 1'b0;
        o_grant  = 2'b00;
        case (state)
            OWN0: begin
                o_grant  = 2'b01;
                o_s_adr  = i_m0_adr;
                o_s_dat  = i_m0_dat;
                o_s_sel  = i_m0_sel;
                o_s_we   = i_m0_we;
                o_s_cyc  = i_m0_cyc && !tmo_hit;
                o_m0_ack = i_s_ack;
                o_m0_rdt = i_s_rdt;
                o_m0_err = tmo_hit;
            end
            OWN1: begin
                o_grant  = 2'b10;
                o_s_adr  = i_m1_adr;
                o_s_dat  = i_m1_dat;
                o_s_sel  = i_m1_sel;
                o_s_we   = i_m1_we;
                o_s_cyc  = i_m1_cyc && !tmo_hit;
                o_m1_ack = i_s_ack;
                o_m1_rdt = i_s_rdt;
                o_m1_err = tmo_hit;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_servant_wb_arbiter.sv
// Bench for servant_wb_arbiter: table of per-cycle vectors plus hand-written
// sequences for reset, held ownership, stall/timeout and reset mid-access.
module tb_servant_wb_arbiter;

    localparam int AW = 32;

    logic          wb_clk = 1'b0;
    logic          wb_rst_n;
    logic [AW-1:0] m0_adr, m1_adr, s_adr;
    logic [31:0]   m0_dat, m1_dat, s_dat, m0_rdt, m1_rdt, s_rdt;
    logic [3:0]    m0_sel, m1_sel, s_sel;
    logic          m0_we, m1_we, s_we, m0_cyc, m1_cyc, s_cyc, s_ack;
    logic          m0_ack, m1_ack, m0_err, m1_err, tmo;
    logic [1:0]    grant;

    int total = 0;
    int bad   = 0;

    always #5 wb_clk = ~wb_clk;

    servant_wb_arbiter #(.AW(AW), .TIMEOUT(16)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .i_m0_we(m0_we), .i_m0_cyc(m0_cyc),
        .o_m0_rdt(m0_rdt), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
        .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we), .i_m1_cyc(m1_cyc),
        .o_m1_rdt(m1_rdt), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
        .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel), .o_s_we(s_we), .o_s_cyc(s_cyc),
        .i_s_rdt(s_rdt), .i_s_ack(s_ack),
        .o_grant(grant), .o_tmo(tmo)
    );

    typedef struct packed {
        logic        c0, c1, ack;
        logic [31:0] rdt;
        logic [1:0]  grant;
        logic        scyc, a0, a1;
        logic [31:0] sadr, r0, r1;
    } vec_t;

    function automatic vec_t mk(input logic c0, c1, ack, input logic [31:0] rdt,
                                input logic [1:0] g, input logic scyc, a0, a1,
                                input logic [31:0] sadr, r0, r1);
        vec_t v;
        v.c0 = c0; v.c1 = c1; v.ack = ack; v.rdt = rdt;
        v.grant = g; v.scyc = scyc; v.a0 = a0; v.a1 = a1;
        v.sadr = sadr; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic do_reset();
        wb_rst_n = 1'b0;
        m0_cyc = 1'b0; m1_cyc = 1'b0; s_ack = 1'b0; s_rdt = '0;
        repeat (2) @(posedge wb_clk);
        #1;
        wb_rst_n = 1'b1;
    endtask

    vec_t tbl[17];

    // Watchdog: the bench never waits on a DUT event, but guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //        c0 c1 ack rdt           grant scyc a0 a1 sadr       r0            r1
        tbl[0]  = mk(1, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,   32'h0,        32'h0);
        tbl[1]  = mk(1, 0, 0, 32'h0,        2'b01, 1, 0, 0, 32'h100, 32'h0,        32'h0);
        tbl[2]  = mk(1, 0, 0, 32'h0,        2'b01, 1, 0, 0, 32'h100, 32'h0,        32'h0);
        tbl[3]  = mk(1, 0, 1, 32'hDEADBEEF, 2'b01, 1, 1, 0, 32'h100, 32'hDEADBEEF, 32'h0);
        tbl[4]  = mk(0, 0, 0, 32'h0,        2'b01, 0, 0, 0, 32'h100, 32'h0,        32'h0);
        tbl[5]  = mk(1, 1, 1, 32'hCAFEF00D, 2'b00, 0, 0, 0, 32'h0,   32'h0,        32'h0);
        tbl[6]  = mk(1, 1, 0, 32'h0,        2'b10, 1, 0, 0, 32'h200, 32'h0,        32'h0);
        tbl[7]  = mk(1, 1, 1, 32'h11111111, 2'b10, 1, 0, 1, 32'h200, 32'h0,        32'h11111111);
        tbl[8]  = mk(1, 0, 0, 32'h0,        2'b10, 0, 0, 0, 32'h200, 32'h0,        32'h0);
        tbl[9]  = mk(1, 1, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,   32'h0,        32'h0);
        tbl[10] = mk(1, 1, 1, 32'h22222222, 2'b01, 1, 1, 0, 32'h100, 32'h22222222, 32'h0);
        tbl[11] = mk(0, 1, 0, 32'h0,        2'b01, 0, 0, 0, 32'h100, 32'h0,        32'h0);
        tbl[12] = mk(1, 1, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,   32'h0,        32'h0);
        tbl[13] = mk(1, 1, 1, 32'h33333333, 2'b10, 1, 0, 1, 32'h200, 32'h0,        32'h33333333);
        tbl[14] = mk(1, 0, 0, 32'h0,        2'b10, 0, 0, 0, 32'h200, 32'h0,        32'h0);
        tbl[15] = mk(0, 1, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,   32'h0,        32'h0);
        tbl[16] = mk(0, 1, 0, 32'h0,        2'b10, 1, 0, 0, 32'h200, 32'h0,        32'h0);

        m0_adr = 32'h100; m0_dat = 32'hA0A0A0A0; m0_sel = 4'hF; m0_we = 1'b0;
        m1_adr = 32'h200; m1_dat = 32'hB1B1B1B1; m1_sel = 4'h3; m1_we = 1'b1;

        // ---- reset held with both masters requesting
        wb_rst_n = 1'b0; m0_cyc = 1'b1; m1_cyc = 1'b1; s_ack = 1'b0; s_rdt = '0;
        repeat (2) @(posedge wb_clk);
        @(negedge wb_clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_scyc", 32'(s_cyc), 32'h0);
        chk("rst_acks", {30'h0, m1_ack, m0_ack}, 32'h0);
        chk("rst_errs", {29'h0, tmo, m1_err, m0_err}, 32'h0);
        chk("rst_sadr", s_adr, 32'h0);
        next_cycle();
        wb_rst_n = 1'b1;
        @(negedge wb_clk);
        chk("rel_grant_idle", 32'(grant), 32'h0);
        next_cycle();
        @(negedge wb_clk);
        chk("rel_grant_m0", 32'(grant), 32'h1);

        // ---- table: one vector per cycle starting from IDLE, last owner M1
        do_reset();
        for (int i = 0; i < 17; i++) begin
            m0_cyc = tbl[i].c0; m1_cyc = tbl[i].c1; s_ack = tbl[i].ack; s_rdt = tbl[i].rdt;
            @(negedge wb_clk);
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
            chk($sformatf("v%0d_scyc", i), 32'(s_cyc), 32'(tbl[i].scyc));
            chk($sformatf("v%0d_ack0", i), 32'(m0_ack), 32'(tbl[i].a0));
            chk($sformatf("v%0d_ack1", i), 32'(m1_ack), 32'(tbl[i].a1));
            chk($sformatf("v%0d_sadr", i), s_adr, tbl[i].sadr);
            chk($sformatf("v%0d_rdt0", i), m0_rdt, tbl[i].r0);
            chk($sformatf("v%0d_rdt1", i), m1_rdt, tbl[i].r1);
            chk($sformatf("v%0d_swe", i), 32'(s_we), 32'(tbl[i].grant == 2'b10));
            chk($sformatf("v%0d_errs", i), {30'h0, m1_err, m0_err}, 32'h0);
            next_cycle();
        end

        // ---- M1 holds the bus over two writes while M0 waits
        do_reset();
        m1_cyc = 1'b1; m1_adr = 32'h10; m1_dat = 32'h55; m1_sel = 4'hF;
        @(negedge wb_clk);
        chk("hold_idle", 32'(grant), 32'h0);
        next_cycle();
        m0_cyc = 1'b1; s_ack = 1'b1;
        @(negedge wb_clk);
        chk("hold_g1", 32'(grant), 32'h2);
        chk("hold_adr1", s_adr, 32'h10);
        chk("hold_dat1", s_dat, 32'h55);
        chk("hold_sel1", 32'(s_sel), 32'hF);
        chk("hold_ack1", {30'h0, m1_ack, m0_ack}, 32'h2);
        next_cycle();
        s_ack = 1'b0; m1_adr = 32'h14; m1_dat = 32'h66;
        @(negedge wb_clk);
        chk("hold_g2", 32'(grant), 32'h2);
        chk("hold_adr2", s_adr, 32'h14);
        next_cycle();
        s_ack = 1'b1;
        @(negedge wb_clk);
        chk("hold_g3", 32'(grant), 32'h2);
        chk("hold_dat2", s_dat, 32'h66);
        chk("hold_ack2", {30'h0, m1_ack, m0_ack}, 32'h2);
        next_cycle();
        s_ack = 1'b0; m1_cyc = 1'b0;
        @(negedge wb_clk);
        chk("hold_drop_g", 32'(grant), 32'h2);
        chk("hold_drop_scyc", 32'(s_cyc), 32'h0);
        next_cycle();
        @(negedge wb_clk);
        chk("hold_gap", 32'(grant), 32'h0);
        next_cycle();
        @(negedge wb_clk);
        chk("hold_m0_g", 32'(grant), 32'h1);
        chk("hold_m0_adr", s_adr, 32'h100);

        // ---- M1 stalls with no slave ack (M0 also requesting)
        do_reset();
        m1_adr = 32'h200;
        m1_cyc = 1'b1;
        next_cycle();                       // IDLE -> OWN1, grant cycle 0 follows
        m0_cyc = 1'b1;
`ifdef SERVANT_WB_ARB_TIMEOUT_EN
        for (int k = 0; k < 15; k++) begin
            @(negedge wb_clk);
            chk($sformatf("stall%0d_g", k), 32'(grant), 32'h2);
            chk($sformatf("stall%0d_err", k), 32'(m1_err), 32'h0);
            next_cycle();
        end
        @(negedge wb_clk);
        chk("tmo_err1", 32'(m1_err), 32'h1);
        chk("tmo_err0", 32'(m0_err), 32'h0);
        chk("tmo_scyc", 32'(s_cyc), 32'h0);
        chk("tmo_sticky_pre", 32'(tmo), 32'h0);
        next_cycle();
        @(negedge wb_clk);
        chk("tmo_idle", 32'(grant), 32'h0);
        chk("tmo_sticky", 32'(tmo), 32'h1);
        chk("tmo_err_clr", 32'(m1_err), 32'h0);
        next_cycle();
        @(negedge wb_clk);
        chk("tmo_m0_next", 32'(grant), 32'h1);
        chk("tmo_sticky2", 32'(tmo), 32'h1);
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge wb_clk);
            chk($sformatf("stall%0d_g", k), 32'(grant), 32'h2);
            chk($sformatf("stall%0d_scyc", k), 32'(s_cyc), 32'h1);
            chk($sformatf("stall%0d_err", k), {29'h0, tmo, m1_err, m0_err}, 32'h0);
            next_cycle();
        end
`endif

        // ---- reset asserted mid-access with an ack pending
        do_reset();
        m0_cyc = 1'b1; m1_cyc = 1'b0;
        next_cycle();
        @(negedge wb_clk);
        chk("mid_own", 32'(grant), 32'h1);
        next_cycle();
        s_ack = 1'b1; s_rdt = 32'h12345678;
        #1;
        wb_rst_n = 1'b0;
        #1;
        chk("mid_grant", 32'(grant), 32'h0);
        chk("mid_scyc", 32'(s_cyc), 32'h0);
        chk("mid_acks", {30'h0, m1_ack, m0_ack}, 32'h0);
        chk("mid_errs", {30'h0, m1_err, m0_err}, 32'h0);
        chk("mid_rdt0", m0_rdt, 32'h0);
        chk("mid_sadr", s_adr, 32'h0);
        @(negedge wb_clk);
        chk("mid_hold", {28'h0, grant, m0_ack, s_cyc}, 32'h0);
        wb_rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
